// File: rtl/idma_burst_splitter_axi_pkg.sv
// Shared types, default widths and burst-size arithmetic for the iDMA AXI
// burst splitter.
package idma_splitter_pkg;

  localparam int unsigned DefAddrWidth  = 32;
  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefTFLenWidth = 32;
  localparam int unsigned DefMaxBeats   = 256;
  localparam int unsigned DefPageSize   = 4096;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // A byte-wide bus still needs a one-bit field so the port widths stay legal.
  function automatic int unsigned off_width(input int unsigned data_width);
    return (data_width > 8) ? $clog2(data_width / 8) : 1;
  endfunction

  localparam int unsigned StrbWidth = strb_width(DefDataWidth);
  localparam int unsigned OffW      = off_width(DefDataWidth);

  typedef enum logic [1:0] {
    SIDE_IDLE = 2'd0,
    SIDE_EMIT = 2'd1,
    SIDE_DONE = 2'd2
  } side_state_e;

  typedef enum logic {
    TOP_IDLE = 1'b0,
    TOP_BUSY = 1'b1
  } top_state_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [OffW-1:0]         offset;
    logic [OffW-1:0]         tailer;
    logic [OffW-1:0]         shift;
  } burst_desc_t;

  // Largest chunk that fits the remaining length, the current page and one
  // max-length burst. The burst room is reduced by the leading misalignment
  // so the beat count never exceeds the burst limit.
  function automatic logic [63:0] chunk_size(input logic [63:0] addr,
                                             input logic [63:0] remaining,
                                             input logic [63:0] page_size,
                                             input logic [63:0] burst_bytes,
                                             input logic [63:0] strb);
    logic [63:0] page_room;
    logic [63:0] burst_room;
    logic [63:0] chunk;
    page_room  = page_size - (addr % page_size);
    burst_room = burst_bytes - (addr % strb);
    chunk      = remaining;
    if (page_room < chunk)  chunk = page_room;
    if (burst_room < chunk) chunk = burst_room;
    return chunk;
  endfunction

endpackage

// File: rtl/idma_burst_splitter_axi_if.sv
// One burst-descriptor channel (AR/AW meta plus datapath shift info).
// master = splitter producing descriptors, slave = transport consuming them.
interface idma_burst_splitter_axi_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned OffW      = 2
);
  logic [AddrWidth-1:0] addr;
  logic [7:0]           len;
  logic [OffW-1:0]      offset;
  logic [OffW-1:0]      tailer;
  logic [OffW-1:0]      shift;
  logic                 valid;
  logic                 ready;

  modport master (output addr, len, offset, tailer, shift, valid, input ready);
  modport slave  (input addr, len, offset, tailer, shift, valid, output ready);
endinterface

// File: rtl/idma_burst_splitter_side.sv
// One side (read or write) of the burst splitter: address/remaining counters,
// side FSM and the registered descriptor output stage.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// SIDE_IDLE | waiting for a transfer load from the top FSM
// SIDE_EMIT | descriptor valid; next burst loaded on each handshake
// SIDE_DONE | last descriptor handshaked; waiting for the top to clear
module idma_burst_splitter_side
  import idma_splitter_pkg::*;
#(
  parameter int unsigned AddrWidth  = DefAddrWidth,
  parameter int unsigned DataWidth  = DefDataWidth,
  parameter int unsigned TFLenWidth = DefTFLenWidth,
  parameter int unsigned MaxBeats   = DefMaxBeats,
  parameter int unsigned PageSize   = DefPageSize
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  clr_i,
  input  logic [AddrWidth-1:0]  addr_i,
  input  logic [TFLenWidth-1:0] length_i,
  output logic                  done_o,
  idma_burst_splitter_axi_if.master desc
);

  localparam int unsigned StrbW   = strb_width(DataWidth);
  localparam logic [63:0] Strb64  = 64'(StrbW);
  localparam logic [63:0] Page64  = 64'(PageSize);
  localparam logic [63:0] Burst64 = 64'(MaxBeats) * Strb64;

  side_state_e           state_q, state_d;
  logic [AddrWidth-1:0]  cur_addr_q, cur_addr_d;
  logic [TFLenWidth-1:0] remaining_q, remaining_d;
  burst_desc_t           desc_q, desc_d;
  logic                  valid_q, valid_d;
  logic                  take;

  logic [63:0] base_addr, base_rem, off_b, chunk_b, end_b, beats_b, tail_b;

  // Burst geometry: from the request on load, else from the running counters.
  always_comb begin
    base_addr = (state_q == SIDE_IDLE) ? 64'(addr_i)   : 64'(cur_addr_q);
    base_rem  = (state_q == SIDE_IDLE) ? 64'(length_i) : 64'(remaining_q);
    off_b     = base_addr % Strb64;
    chunk_b   = chunk_size(base_addr, base_rem, Page64, Burst64, Strb64);
    end_b     = off_b + chunk_b;
    beats_b   = (end_b + Strb64 - 64'd1) / Strb64;
    tail_b    = (Strb64 - (end_b % Strb64)) % Strb64;
  end

  // Side FSM and next-descriptor selection.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    desc_d      = desc_q;
    valid_d     = valid_q;
    take        = 1'b0;

    unique case (state_q)
      SIDE_IDLE: begin
        if (load_i) begin
          state_d = SIDE_EMIT;
          take    = 1'b1;
        end
      end
      SIDE_EMIT: begin
        if (valid_q && desc.ready) begin
          if (remaining_q == '0) begin
            valid_d = 1'b0;
            state_d = SIDE_DONE;
          end else begin
            take = 1'b1;
          end
        end
      end
      SIDE_DONE: begin
        if (clr_i) state_d = SIDE_IDLE;
      end
      default: state_d = SIDE_IDLE;
    endcase

    if (take) begin
      valid_d       = 1'b1;
      desc_d.addr   = DefAddrWidth'(base_addr);
      desc_d.len    = 8'(beats_b - 64'd1);
      desc_d.offset = OffW'(off_b);
      desc_d.tailer = OffW'(tail_b);
      // The shift is fixed by the transfer's start alignment.
      desc_d.shift  = (state_q == SIDE_IDLE) ? OffW'(off_b) : desc_q.shift;
      cur_addr_d    = AddrWidth'(base_addr + chunk_b);
      remaining_d   = TFLenWidth'(base_rem - chunk_b);
    end
  end

  // Counter, FSM and output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SIDE_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      desc_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      desc_q      <= desc_d;
      valid_q     <= valid_d;
    end
  end

  assign done_o      = (state_q == SIDE_DONE);
  assign desc.addr   = AddrWidth'(desc_q.addr);
  assign desc.len    = desc_q.len;
  assign desc.offset = desc_q.offset;
  assign desc.tailer = desc_q.tailer;
  assign desc.shift  = desc_q.shift;
  assign desc.valid  = valid_q;

endmodule

// File: rtl/idma_burst_splitter_axi.sv
// iDMA AXI burst splitter: accepts one 1D transfer and hands it to two
// independent side splitters (read from src, write to dst).
//
// state    | meaning
// ---------+----------------------------------------------------------
// TOP_IDLE | ready for a new transfer
// TOP_BUSY | sides emitting; leaves when both sides report done
module idma_burst_splitter_axi
  import idma_splitter_pkg::*;
#(
  parameter int unsigned AddrWidth  = DefAddrWidth,
  parameter int unsigned DataWidth  = DefDataWidth,
  parameter int unsigned TFLenWidth = DefTFLenWidth,
  parameter int unsigned MaxBeats   = DefMaxBeats,
  parameter int unsigned PageSize   = DefPageSize
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [AddrWidth-1:0]  src_addr_i,
  input  logic [AddrWidth-1:0]  dst_addr_i,
  input  logic [TFLenWidth-1:0] length_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic                  busy_o,
  idma_burst_splitter_axi_if.master r_if,
  idma_burst_splitter_axi_if.master w_if
);

  top_state_e state_q, state_d;
  logic       load, clr, r_done, w_done;

  assign req_ready_o = (state_q == TOP_IDLE);
  assign busy_o      = (state_q == TOP_BUSY);
  // Zero-length requests are handshaked but never reach the sides.
  assign load        = req_valid_i && req_ready_o && (length_i != '0);
  assign clr         = busy_o && r_done && w_done;

  // Top next-state logic.
  always_comb begin
    state_d = state_q;
    if (state_q == TOP_IDLE) begin
      if (load) state_d = TOP_BUSY;
    end else if (r_done && w_done) begin
      state_d = TOP_IDLE;
    end
  end

  // Top state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= TOP_IDLE;
    else         state_q <= state_d;
  end

  idma_burst_splitter_side #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .TFLenWidth(TFLenWidth),
    .MaxBeats  (MaxBeats),
    .PageSize  (PageSize)
  ) u_read (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .clr_i   (clr),
    .addr_i  (src_addr_i),
    .length_i(length_i),
    .done_o  (r_done),
    .desc    (r_if)
  );

  idma_burst_splitter_side #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .TFLenWidth(TFLenWidth),
    .MaxBeats  (MaxBeats),
    .PageSize  (PageSize)
  ) u_write (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .clr_i   (clr),
    .addr_i  (dst_addr_i),
    .length_i(length_i),
    .done_o  (w_done),
    .desc    (w_if)
  );

endmodule

// File: tb/tb_idma_burst_splitter_axi.sv
// Self-checking bench for idma_burst_splitter_axi (32-bit bus, 256 beats,
// 4 KiB pages): directed vectors plus random transfers against a reference
// model of the splitting rules.
module tb_idma_burst_splitter_axi;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  off;
    logic [1:0]  tail;
    logic [1:0]  shift;
  } d_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] src_addr_i, dst_addr_i, length_i;
  logic        req_valid_i, req_ready_o, busy_o;

  idma_burst_splitter_axi_if #(.AddrWidth(32), .OffW(2)) r_if ();
  idma_burst_splitter_axi_if #(.AddrWidth(32), .OffW(2)) w_if ();

  idma_burst_splitter_axi dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .length_i   (length_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .busy_o     (busy_o),
    .r_if       (r_if),
    .w_if       (w_if)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  d_t exp_r[$];
  d_t exp_w[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the transfer with the splitting rules.
  function automatic void model_side(input logic [31:0] base, input logic [31:0] n, input bit is_r);
    int unsigned a, rem, off, page_left, chunk, last;
    d_t d;
    a   = base;
    rem = n;
    while (rem != 0) begin
      off       = a % 4;
      page_left = 4096 - (a % 4096);
      chunk     = rem;
      if (page_left < chunk)    chunk = page_left;
      if ((1024 - off) < chunk) chunk = 1024 - off;
      last      = off + chunk;
      d.addr    = a;
      d.len     = 8'((last + 3) / 4 - 1);
      d.off     = 2'(off);
      d.tail    = 2'((4 - (last % 4)) % 4);
      d.shift   = base[1:0];
      if (is_r) exp_r.push_back(d);
      else      exp_w.push_back(d);
      a   = a + chunk;
      rem = rem - chunk;
    end
  endfunction

  task automatic cmp_desc(input string side, input d_t e, input logic [31:0] a,
                          input logic [7:0] l, input logic [1:0] o, input logic [1:0] t,
                          input logic [1:0] s);
    check({side, "_addr"},   64'(a), 64'(e.addr));
    check({side, "_len"},    64'(l), 64'(e.len));
    check({side, "_offset"}, 64'(o), 64'(e.off));
    check({side, "_tailer"}, 64'(t), 64'(e.tail));
    check({side, "_shift"},  64'(s), 64'(e.shift));
  endtask

  // Issue one nonzero transfer and drain both channels against the queues.
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                          input int r_hold, input int rdy_pct);
    int cyc, hold;
    bit r_st, w_st, r_rdy, w_rdy;
    logic [46:0] r_snap, w_snap;
    d_t d;
    @(negedge clk_i);
    src_addr_i  = src;
    dst_addr_i  = dst;
    length_i    = len;
    req_valid_i = 1'b1;
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("r_valid_first", 64'(r_if.valid), 64'd1);
    check("w_valid_first", 64'(w_if.valid), 64'd1);
    cyc  = 0;
    hold = r_hold;
    r_st = 1'b0;
    w_st = 1'b0;
    while ((exp_r.size() != 0 || exp_w.size() != 0) && cyc < 3000) begin
      check("busy_during", 64'(busy_o), 64'd1);
      if (r_st) check("r_hold_stable", 64'({r_if.valid, r_if.addr, r_if.len, r_if.offset, r_if.tailer, r_if.shift}), 64'(r_snap));
      if (w_st) check("w_hold_stable", 64'({w_if.valid, w_if.addr, w_if.len, w_if.offset, w_if.tailer, w_if.shift}), 64'(w_snap));
      if (hold > 0) begin
        r_rdy = 1'b0;
        hold--;
      end else begin
        r_rdy = ($urandom_range(99, 0) < rdy_pct);
      end
      w_rdy  = ($urandom_range(99, 0) < rdy_pct);
      r_st   = r_if.valid && !r_rdy;
      w_st   = w_if.valid && !w_rdy;
      r_snap = {r_if.valid, r_if.addr, r_if.len, r_if.offset, r_if.tailer, r_if.shift};
      w_snap = {w_if.valid, w_if.addr, w_if.len, w_if.offset, w_if.tailer, w_if.shift};
      if (r_if.valid && r_rdy) begin
        if (exp_r.size() == 0) check("r_unexpected_valid", 64'(r_if.valid), 64'd0);
        else begin
          d = exp_r.pop_front();
          cmp_desc("r", d, r_if.addr, r_if.len, r_if.offset, r_if.tailer, r_if.shift);
        end
      end
      if (w_if.valid && w_rdy) begin
        if (exp_w.size() == 0) check("w_unexpected_valid", 64'(w_if.valid), 64'd0);
        else begin
          d = exp_w.pop_front();
          cmp_desc("w", d, w_if.addr, w_if.len, w_if.offset, w_if.tailer, w_if.shift);
        end
      end
      r_if.ready = r_rdy;
      w_if.ready = w_rdy;
      @(negedge clk_i);
      cyc++;
    end
    check("xfer_in_budget", 64'(cyc < 3000), 64'd1);
    exp_r.delete();
    exp_w.delete();
    r_if.ready = 1'b0;
    w_if.ready = 1'b0;
    check("r_valid_after", 64'(r_if.valid), 64'd0);
    check("w_valid_after", 64'(w_if.valid), 64'd0);
    check("req_ready_lag", 64'(req_ready_o), 64'd0);
    @(negedge clk_i);
    check("req_ready_back", 64'(req_ready_o), 64'd1);
    check("busy_cleared", 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic [31:0] rs, rd, rl;
    req_valid_i = 1'b0;
    src_addr_i  = '0;
    dst_addr_i  = '0;
    length_i    = '0;
    r_if.ready  = 1'b0;
    w_if.ready  = 1'b0;

    // Reset state
    @(negedge clk_i);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_busy",      64'(busy_o), 64'd0);
    check("rst_r_valid",   64'(r_if.valid), 64'd0);
    check("rst_w_valid",   64'(w_if.valid), 64'd0);
    check("rst_r_fields",  64'({r_if.addr, r_if.len, r_if.offset, r_if.tailer, r_if.shift}), 64'd0);
    check("rst_w_fields",  64'({w_if.addr, w_if.len, w_if.offset, w_if.tailer, w_if.shift}), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single aligned burst each side
    exp_r.push_back('{32'h0,   8'd3, 2'd0, 2'd0, 2'd0});
    exp_w.push_back('{32'h100, 8'd3, 2'd0, 2'd0, 2'd0});
    run_xfer(32'h0, 32'h100, 32'd16, 0, 100);

    // Page crossing with misaligned source
    exp_r.push_back('{32'hFFE,  8'd0, 2'd2, 2'd0, 2'd2});
    exp_r.push_back('{32'h1000, 8'd1, 2'd0, 2'd2, 2'd2});
    exp_w.push_back('{32'h2000, 8'd1, 2'd0, 2'd0, 2'd0});
    run_xfer(32'hFFE, 32'h2000, 32'd8, 0, 100);

    // Max-burst split
    exp_r.push_back('{32'h0,   8'd255, 2'd0, 2'd0, 2'd0});
    exp_r.push_back('{32'h400, 8'd255, 2'd0, 2'd0, 2'd0});
    exp_w.push_back('{32'h0,   8'd255, 2'd0, 2'd0, 2'd0});
    exp_w.push_back('{32'h400, 8'd255, 2'd0, 2'd0, 2'd0});
    run_xfer(32'h0, 32'h0, 32'd2048, 0, 100);

    // Zero length: handshake only
    @(negedge clk_i);
    src_addr_i  = 32'h40;
    dst_addr_i  = 32'h80;
    length_i    = 32'd0;
    req_valid_i = 1'b1;
    check("len0_req_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("len0_req_ready_hold", 64'(req_ready_o), 64'd1);
      check("len0_busy",           64'(busy_o), 64'd0);
      check("len0_valids",         64'({r_if.valid, w_if.valid}), 64'd0);
      @(negedge clk_i);
    end

    // Read stall for 5 cycles over a 3-burst transfer
    exp_r.push_back('{32'hC02,  8'd255, 2'd2, 2'd0, 2'd2});
    exp_r.push_back('{32'h1000, 8'd255, 2'd0, 2'd0, 2'd2});
    exp_r.push_back('{32'h1400, 8'd64,  2'd0, 2'd2, 2'd2});
    exp_w.push_back('{32'h0,    8'd255, 2'd0, 2'd0, 2'd0});
    exp_w.push_back('{32'h400,  8'd255, 2'd0, 2'd0, 2'd0});
    exp_w.push_back('{32'h800,  8'd63,  2'd0, 2'd0, 2'd0});
    run_xfer(32'hC02, 32'h0, 32'h900, 5, 100);

    // Reset mid-transfer
    @(negedge clk_i);
    src_addr_i  = 32'h0;
    dst_addr_i  = 32'h0;
    length_i    = 32'd4096;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    r_if.ready  = 1'b1;
    w_if.ready  = 1'b1;
    @(negedge clk_i);
    check("pre_rst_r_valid", 64'(r_if.valid), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_r_valid",   64'(r_if.valid), 64'd0);
    check("midrst_w_valid",   64'(w_if.valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready_o), 64'd1);
    check("midrst_busy",      64'(busy_o), 64'd0);
    check("midrst_r_addr",    64'(r_if.addr), 64'd0);
    @(negedge clk_i);
    rst_ni     = 1'b1;
    r_if.ready = 1'b0;
    w_if.ready = 1'b0;
    @(negedge clk_i);
    check("postrst_r_valid", 64'(r_if.valid), 64'd0);
    exp_r.push_back('{32'h0,   8'd3, 2'd0, 2'd0, 2'd0});
    exp_w.push_back('{32'h100, 8'd3, 2'd0, 2'd0, 2'd0});
    run_xfer(32'h0, 32'h100, 32'd16, 0, 100);

    // Random transfers with random backpressure against the model
    for (int k = 0; k < 20; k++) begin
      rs = $urandom;
      rd = $urandom;
      if (k < 10) begin
        rs = rs & 32'h0000_3FFF;
        rd = rd & 32'h0000_3FFF;
      end
      rl = $urandom_range(5000, 1);
      model_side(rs, rl, 1'b1);
      model_side(rd, rl, 1'b0);
      run_xfer(rs, rd, rl, 0, 60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
